multichannel_sample_player: RTL and testbench
=============================================

# multichannel_sample_player

Parametrised successor to the fixed stereo sample output: accepts N-channel audio frames over a valid/ready handshake, buffers them in a frame FIFO, and plays them out at a programmable sample rate derived from the system clock. It sits between the simulation-side sample fetch (or any upstream frame producer) and the DUT audio inputs. It adds three things the stereo output lacks: decoupling of producer timing from playback rate, configurable output width, and defined underrun behaviour.

## Interface

Parameters:
- CHANNELS, 2: channels per frame, 1..8
- IN_WIDTH, 32: signed bits per input sample
- OUT_WIDTH, 24: signed bits per output sample, 1..IN_WIDTH
- DEPTH, 16: FIFO depth in frames, power of two, at least 2
- DIVIDER, 4: clock cycles per output sample, at least 1
- UNDERRUN_MODE, 0: 0 = hold last frame, 1 = output zero

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  playback enable; when low, the divider freezes and no pops occur
- in_frame  in  CHANNELS*IN_WIDTH  input frame, channel 0 in the LSBs
- in_valid  in  1  in_frame is valid
- in_ready  out  1  FIFO can accept a frame
- audio_out  out  CHANNELS*OUT_WIDTH  current output frame, channel 0 in the LSBs
- out_strobe  out  1  one-cycle pulse when audio_out is updated
- underrun  out  1  sticky; set on the first underrun, cleared only by reset
- underrun_count  out  16  saturating count of underrun ticks
- level  out  $clog2(DEPTH)+1  frames currently in the FIFO

## Operation

- Push: a frame is accepted on the rising edge where in_valid && in_ready.
- in_ready is combinational: level < DEPTH. It does not account for a same-cycle pop, so a full FIFO never accepts a frame, even on a tick.
- Divider:
  - Counter runs 0..DIVIDER-1 while enable is high.
  - The internal tick is true when the counter equals DIVIDER-1; the counter wraps to 0 on that edge.
  - With DIVIDER=1 the tick is true every enabled cycle.
- On a tick edge with level > 0:
  - Pop the oldest frame.
  - Register each channel as its OUT_WIDTH most-significant bits, i.e. in[IN_WIDTH-1 -: OUT_WIDTH]. This is truncation toward negative infinity, with no rounding.
- On a tick edge with level == 0 (underrun):
  - audio_out holds its value (mode 0) or becomes all zeros (mode 1).
  - Set underrun; increment underrun_count, saturating at 65535.
- out_strobe goes high for the single cycle after every tick edge, whether the tick popped a frame or underran.
- Simultaneous push and tick with 0 < level < DEPTH: both happen, so level is unchanged.
- Push into an empty FIFO on a tick edge: this counts as an underrun. The pushed frame plays on the next tick.
- Deasserting enable mid-period freezes the divider count. Playback resumes from the same count, and pushes continue while enable is low.

## Timing

- Reset values (async assert; takes effect on the first edge after deassert):
  - audio_out 0, out_strobe 0, underrun 0, underrun_count 0, level 0.
  - Divider 0, FIFO pointers 0.
  - in_ready is 1 immediately after reset.
- Reset mid-operation discards all buffered frames without emitting them.
- Latency: a frame pushed at edge t can be popped at the earliest tick edge ≥ t+1. audio_out and out_strobe change on that edge.
- Throughput: one frame per DIVIDER cycles out; up to one frame per cycle in.
- level updates on the same edge as the push or pop.

## Structure

- Shared package holds:
  - Mode constants UNDERRUN_HOLD=0 and UNDERRUN_ZERO=1.
  - The channel slice function that extracts channel k from a packed frame.
- One sub-module, sample_frame_fifo: a synchronous FIFO with width CHANNELS*IN_WIDTH and depth DEPTH, wrap-bit pointers, and level output.
- Divider, truncation and underrun logic stay in the top module.

## Test plan

- Reset then idle, enable=1, DIVIDER=4, no pushes:
  - out_strobe pulses every 4 cycles.
  - underrun=1 after the first tick; underrun_count reaches 3 after 3 ticks.
  - audio_out stays 0.
- CHANNELS=2, IN_WIDTH=32, OUT_WIDTH=24: push one frame {ch1=32'h8000_00FF, ch0=32'h1234_5678}.
  - On the next tick: ch0=24'h123456, ch1=24'h800000.
  - level returns 0.
- DEPTH=16: push 20 frames back-to-back with enable=0.
  - in_ready drops after 16 accepts; level=16.
  - Frames 17..20 are held off by the producer.
  - Enable then plays the 16 frames in order.
- Underrun modes: push 1 frame with value 5 on all channels, then let 2 ticks pass.
  - Mode 0: audio_out stays 5.
  - Mode 1: audio_out becomes 0 on the second tick.
- Assert in_valid exactly on a tick edge with level=1.
  - Pop and push both occur; level stays 1.
  - Output order is preserved.
- Assert reset_n low mid-stream with level=5.
  - All outputs are 0 immediately.
  - After release, level=0 and underrun=0; the 5 old frames are never output.

Source files
------------

// File: rtl/multichannel_sample_player_pkg.sv
// Shared constants and helpers for the multichannel sample player.
package multichannel_sample_player_pkg;

    localparam int UNDERRUN_HOLD = 0;
    localparam int UNDERRUN_ZERO = 1;

    // Upper bounds for the generic channel slice helper.
    localparam int MAX_CHANNELS = 8;
    localparam int MAX_IN_WIDTH = 64;
    localparam int MAX_FRAME_W  = MAX_CHANNELS * MAX_IN_WIDTH;

    // Extract channel k (width w) from a packed frame, channel 0 in the LSBs.
    function automatic logic [MAX_IN_WIDTH-1:0] chan_slice(
        input logic [MAX_FRAME_W-1:0] frame,
        input int                     k,
        input int                     w
    );
        logic [MAX_FRAME_W-1:0]  shifted;
        logic [MAX_IN_WIDTH-1:0] mask;
        shifted    = frame >> (k * w);
        mask       = {MAX_IN_WIDTH{1'b1}} >> (MAX_IN_WIDTH - w);
        chan_slice = shifted[MAX_IN_WIDTH-1:0] & mask;
    endfunction

endpackage

// File: rtl/multichannel_sample_player_if.sv
// Frame ingress handshake: producer drives frame/valid, player returns ready.
interface multichannel_sample_player_if #(
    parameter int CHANNELS = 2,
    parameter int IN_WIDTH = 32
);
    logic [CHANNELS*IN_WIDTH-1:0] in_frame;
    logic                         in_valid;
    logic                         in_ready;

    modport master (output in_frame, output in_valid, input in_ready);
    modport slave  (input in_frame, input in_valid, output in_ready);
endinterface

// File: rtl/multichannel_sample_player_sample_frame_fifo.sv
// Synchronous frame FIFO with wrap-bit pointers and an occupancy output.
// Latency: written entry visible at the head on the edge after the push.
// Backpressure: full blocks pushes; pops on empty are ignored.
module sample_frame_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Same index, different wrap bit means the FIFO has lapped itself.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/multichannel_sample_player.sv
// Buffers N-channel frames and plays them out once every DIVIDER enabled cycles.
// Latency: frame pushed at edge t pops on the first tick edge at or after t+1.
// Backpressure: in_ready low while the FIFO is full, regardless of a same-cycle pop.
module multichannel_sample_player
    import multichannel_sample_player_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int IN_WIDTH      = 32,
    parameter int OUT_WIDTH     = 24,
    parameter int DEPTH         = 16,
    parameter int DIVIDER       = 4,
    parameter int UNDERRUN_MODE = UNDERRUN_HOLD
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enable,
    multichannel_sample_player_if.slave   in_if,
    output logic [CHANNELS*OUT_WIDTH-1:0] audio_out,
    output logic                          out_strobe,
    output logic                          underrun,
    output logic [15:0]                   underrun_count,
    output logic [$clog2(DEPTH):0]        level
);
    localparam int FRAME_W = CHANNELS * IN_WIDTH;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int DIV_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    logic [DIV_W-1:0]              div_q, div_d;
    logic [CHANNELS*OUT_WIDTH-1:0] audio_q, audio_d;
    logic                          strobe_q, strobe_d;
    logic                          underrun_q, underrun_d;
    logic [15:0]                   urun_cnt_q, urun_cnt_d;

    logic                          tick;
    logic                          push;
    logic                          pop;
    logic [FRAME_W-1:0]            head_dat;
    logic [LVL_W-1:0]              fifo_level;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [CHANNELS*OUT_WIDTH-1:0] trunc_frame;
    logic [MAX_IN_WIDTH-1:0]       samp;

    assign tick         = enable && (div_q == DIV_W'(DIVIDER - 1));
    assign in_if.in_ready = !fifo_full;
    assign push         = in_if.in_valid && !fifo_full;
    assign pop          = tick && !fifo_empty;

    sample_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push_vld (push),
        .push_dat (in_if.in_frame),
        .pop_vld  (pop),
        .pop_dat  (head_dat),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Keep the top OUT_WIDTH bits of each channel: plain truncation, no rounding.
    always_comb begin
        trunc_frame = '0;
        samp        = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            samp = chan_slice(MAX_FRAME_W'(head_dat), k, IN_WIDTH);
            trunc_frame[k*OUT_WIDTH +: OUT_WIDTH] = samp[IN_WIDTH-1 -: OUT_WIDTH];
        end
    end

    always_comb begin
        div_d      = div_q;
        audio_d    = audio_q;
        strobe_d   = tick;
        underrun_d = underrun_q;
        urun_cnt_d = urun_cnt_q;
        if (enable) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        if (pop) begin
            audio_d = trunc_frame;
        end else if (tick) begin
            // A push landing on this same edge still counts as an underrun.
            if (UNDERRUN_MODE == UNDERRUN_ZERO) audio_d = '0;
            underrun_d = 1'b1;
            if (urun_cnt_q != 16'hFFFF) urun_cnt_d = urun_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            audio_q    <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            urun_cnt_q <= '0;
        end else begin
            div_q      <= div_d;
            audio_q    <= audio_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign audio_out      = audio_q;
    assign out_strobe     = strobe_q;
    assign underrun       = underrun_q;
    assign underrun_count = urun_cnt_q;
    assign level          = fifo_level;

endmodule

// File: tb/tb_multichannel_sample_player.sv
// Directed bench: hold-mode and zero-mode players share one stimulus stream.
module tb_multichannel_sample_player;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [63:0] in_frame;
    logic        in_valid;

    logic [47:0] audio0, audio1;
    logic        strobe0, strobe1;
    logic        urun0, urun1;
    logic [15:0] ucnt0, ucnt1;
    logic [4:0]  level0, level1;

    int n_chk  = 0;
    int n_pass = 0;

    multichannel_sample_player_if #(.CHANNELS(2), .IN_WIDTH(32)) if0 ();
    multichannel_sample_player_if #(.CHANNELS(2), .IN_WIDTH(32)) if1 ();

    assign if0.in_frame = in_frame;
    assign if0.in_valid = in_valid;
    assign if1.in_frame = in_frame;
    assign if1.in_valid = in_valid;

    multichannel_sample_player #(
        .CHANNELS(2), .IN_WIDTH(32), .OUT_WIDTH(24), .DEPTH(16), .DIVIDER(4), .UNDERRUN_MODE(0)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .in_if          (if0.slave),
        .audio_out      (audio0),
        .out_strobe     (strobe0),
        .underrun       (urun0),
        .underrun_count (ucnt0),
        .level          (level0)
    );

    multichannel_sample_player #(
        .CHANNELS(2), .IN_WIDTH(32), .OUT_WIDTH(24), .DEPTH(16), .DIVIDER(4), .UNDERRUN_MODE(1)
    ) dut_zero (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .in_if          (if1.slave),
        .audio_out      (audio1),
        .out_strobe     (strobe1),
        .underrun       (urun1),
        .underrun_count (ucnt1),
        .level          (level1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (strobe0 !== 1'b1 && n < 20);
        chk({tag, "_strobe"}, strobe0, 1);
    endtask

    initial begin
        logic [31:0] c0;
        logic [47:0] exp_a;
        logic [47:0] exp_b;

        reset_n  = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_frame = '0;
        repeat (3) @(negedge clock);
        chk("rst_audio",    audio0,      0);
        chk("rst_strobe",   strobe0,     0);
        chk("rst_underrun", urun0,       0);
        chk("rst_count",    ucnt0,       0);
        chk("rst_level",    level0,      0);
        chk("rst_ready",    if0.in_ready, 1);

        // Idle playback: tick every 4th enabled edge, each one an underrun.
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            chk($sformatf("idle_strobe_%0d", i), strobe0, (i % 4 == 0));
            if (i == 3) chk("idle_urun_before", urun0, 0);
            if (i == 4) chk("idle_urun_first",  urun0, 1);
        end
        chk("idle_count3", ucnt0,  3);
        chk("idle_audio0", audio0, 0);
        chk("idle_audio1", audio1, 0);

        // Truncation of a single frame.
        in_frame = {32'h8000_00FF, 32'h1234_5678};
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        chk("trunc_level1", level0, 1);
        wait_strobe("trunc");
        chk("trunc_audio", audio0, 48'h800000_123456);
        chk("trunc_level0", level0, 0);
        chk("trunc_count", ucnt0, 3);

        // Underrun modes: one frame of 5s, then an empty tick.
        in_frame = {32'h0000_0500, 32'h0000_0500};
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        wait_strobe("mode_play");
        chk("mode_play_hold", audio0, 48'h000005_000005);
        chk("mode_play_zero", audio1, 48'h000005_000005);
        wait_strobe("mode_urun");
        chk("mode_urun_hold", audio0, 48'h000005_000005);
        chk("mode_urun_zero", audio1, 0);
        chk("mode_urun_count", ucnt0, 4);
        chk("mode_urun_count_z", ucnt1, 4);

        // Push landing on a tick edge with level 1.
        in_frame = {32'hFFEE_DDCC, 32'h0011_2233};
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        in_frame = {32'h0000_0100, 32'h7FFF_FFFF};
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        chk("simul_strobe", strobe0, 1);
        chk("simul_audio_a", audio0, 48'hFFEEDD_001122);
        chk("simul_level", level0, 1);
        wait_strobe("simul_b");
        chk("simul_audio_b", audio0, 48'h000001_7FFFFF);
        chk("simul_level0", level0, 0);

        // Fill to depth with playback frozen; producer holds off extra frames.
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            c0       = 32'(i) << 8;
            in_frame = {~c0, c0};
            in_valid = 1'b1;
            @(negedge clock);
            chk($sformatf("fill_level_%0d", i), level0, (i + 1 < 16) ? i + 1 : 16);
            chk($sformatf("fill_ready_%0d", i), if0.in_ready, (i + 1 < 16));
            chk($sformatf("fill_strobe_%0d", i), strobe0, 0);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_strobe($sformatf("drain_%0d", k));
            c0    = 32'(k) << 8;
            exp_a = {~c0[31:8], c0[31:8]};
            chk($sformatf("drain_audio_%0d", k), audio0, exp_a);
            chk($sformatf("drain_level_%0d", k), level0, 15 - k);
        end
        wait_strobe("drain_urun");
        exp_b = {~24'd15, 24'd15};
        chk("drain_urun_hold", audio0, exp_b);
        chk("drain_urun_count", ucnt0, 5);

        // Reset with 5 frames buffered.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_frame = {32'hDEAD_0000 + 32'(i), 32'hBEEF_0000 + 32'(i)};
            in_valid = 1'b1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("pre_rst_level", level0, 5);
        reset_n = 1'b0;
        #1;
        chk("arst_audio",    audio0, 0);
        chk("arst_audio_z",  audio1, 0);
        chk("arst_strobe",   strobe0, 0);
        chk("arst_underrun", urun0, 0);
        chk("arst_count",    ucnt0, 0);
        chk("arst_level",    level0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        enable  = 1'b1;
        chk("post_rst_level", level0, 0);
        chk("post_rst_urun",  urun0, 0);
        chk("post_rst_ready", if0.in_ready, 1);
        wait_strobe("post_rst");
        chk("post_rst_audio", audio0, 0);
        chk("post_rst_urun1", urun0, 1);
        chk("post_rst_count", ucnt0, 1);
        chk("post_rst_level0", level0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
